// File: rtl/clcd_pkg.sv
// Shared constants, state encodings and helpers for the character-LCD controller.
package clcd_pkg;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_LINE0    = 8'h80;
  localparam logic [7:0] CMD_LINE1    = 8'hC0;
  localparam logic [7:0] CHAR_SPACE   = 8'h20;

  typedef enum logic [1:0] {
    StPwrWait,
    StInit,
    StIdle,
    StRefresh
  } top_state_e;

  typedef enum logic [2:0] {
    BusIdle,
    BusSetup,
    BusEHi,
    BusWait,
    BusDone
  } bus_state_e;

  // Power-on command sequence, indexed 0..4.
  function automatic logic [7:0] init_cmd(input logic [5:0] idx);
    case (idx)
      6'd0, 6'd1: init_cmd = CMD_FUNC_SET;
      6'd2:       init_cmd = CMD_DISP_ON;
      6'd3:       init_cmd = CMD_CLEAR;
      default:    init_cmd = CMD_ENTRY;
    endcase
  endfunction

  // Counter width able to reach (largest cycle count - 1).
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/clcd_bus_cycle.sv
// One LCD bus write per start/done handshake: 2-cycle setup, E pulse, settle wait, done.
module clcd_bus_cycle
  import clcd_pkg::*;
#(
  parameter int unsigned E_HIGH_CYC   = 16,
  parameter int unsigned CMD_WAIT_CYC = 2500,
  parameter int unsigned CLR_WAIT_CYC = 100000,
  parameter int unsigned CntW         = 20
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       done,
  output logic       CLCD_RS,
  output logic       CLCD_RW,
  output logic       CLCD_E,
  output logic [7:0] CLCD_DQ
);

  localparam logic [CntW-1:0] SetupLast = CntW'(1);
  localparam logic [CntW-1:0] EHiLast   = CntW'(E_HIGH_CYC - 1);
  localparam logic [CntW-1:0] CmdLast   = CntW'(CMD_WAIT_CYC - 1);
  localparam logic [CntW-1:0] ClrLast   = CntW'(CLR_WAIT_CYC - 1);

  bus_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic            rs_q;
  logic            e_q;
  logic            long_q;
  logic [7:0]      dq_q;
  logic [CntW-1:0] wait_last;

  assign wait_last = long_q ? ClrLast : CmdLast;

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q <= BusIdle;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      e_q     <= 1'b0;
      long_q  <= 1'b0;
      dq_q    <= 8'h00;
    end else begin
      unique case (state_q)
        // Done also accepts a start so back-to-back bytes leave no idle gap.
        BusIdle, BusDone: begin
          if (start) begin
            state_q <= BusSetup;
            cnt_q   <= '0;
            rs_q    <= rs;
            dq_q    <= data;
            long_q  <= long_wait;
          end else begin
            state_q <= BusIdle;
          end
        end
        BusSetup: begin
          if (cnt_q == SetupLast) begin
            state_q <= BusEHi;
            cnt_q   <= '0;
            e_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        BusEHi: begin
          if (cnt_q == EHiLast) begin
            state_q <= BusWait;
            cnt_q   <= '0;
            e_q     <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        BusWait: begin
          if (cnt_q == wait_last) begin
            state_q <= BusDone;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= BusIdle;
      endcase
    end
  end

  assign done    = (state_q == BusDone);
  assign CLCD_RS = rs_q;
  assign CLCD_RW = 1'b0;
  assign CLCD_E  = e_q;
  assign CLCD_DQ = dq_q;

endmodule

// File: rtl/clcd_ctrl.sv
// 2x16 character-LCD controller: power-on init, then full repaint whenever the buffer changes.
// Define CLCD_RDBACK_EN to add a registered buffer read port (rd_addr/rd_data).
module clcd_ctrl
  import clcd_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned PWR_WAIT_CYC = CLK_HZ / 1000 * 15,
  parameter int unsigned E_HIGH_CYC   = 16,
  parameter int unsigned CMD_WAIT_CYC = CLK_HZ / 20000,
  parameter int unsigned CLR_WAIT_CYC = CLK_HZ / 500
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
`ifdef CLCD_RDBACK_EN
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
`endif
  output logic       busy,
  output logic       CLCD_RS,
  output logic       CLCD_RW,
  output logic       CLCD_E,
  output logic [7:0] CLCD_DQ
);

  localparam int unsigned CntW = cnt_width(PWR_WAIT_CYC, E_HIGH_CYC, CMD_WAIT_CYC, CLR_WAIT_CYC);
  localparam logic [CntW-1:0] PwrLast     = CntW'(PWR_WAIT_CYC - 1);
  localparam logic [5:0]      InitLastIdx = 6'd4;
  localparam logic [5:0]      RefLastIdx  = 6'd33;

  top_state_e      state_q;
  logic [CntW-1:0] pwr_cnt_q;
  logic [5:0]      idx_q;
  logic            dirty_q, dirty_d;
  logic            busy_q, busy_d;
  logic [7:0]      char_q [32];

  logic            start;
  logic [5:0]      issue_idx;
  logic [4:0]      pos;
  logic            bus_rs;
  logic [7:0]      bus_data;
  logic            long_wait;
  logic            bus_done;
  logic            idle_next;

  // Which byte goes out next and whether to launch it this cycle.
  always_comb begin
    start     = 1'b0;
    issue_idx = '0;
    unique case (state_q)
      StPwrWait: start = (pwr_cnt_q == PwrLast);
      StInit: begin
        issue_idx = idx_q + 6'd1;
        start     = bus_done && (idx_q != InitLastIdx);
      end
      StIdle:    start = dirty_q;
      StRefresh: begin
        issue_idx = idx_q + 6'd1;
        start     = bus_done && (idx_q != RefLastIdx);
      end
      default: start = 1'b0;
    endcase
  end

  // Refresh byte 0 is the line-0 address, 17 the line-1 address, the rest are characters.
  always_comb begin
    pos      = (issue_idx <= 6'd16) ? 5'(issue_idx - 6'd1) : 5'(issue_idx - 6'd2);
    bus_rs   = 1'b0;
    bus_data = init_cmd(issue_idx);
    if (state_q == StIdle || state_q == StRefresh) begin
      if (issue_idx == 6'd0) begin
        bus_data = CMD_LINE0;
      end else if (issue_idx == 6'd17) begin
        bus_data = CMD_LINE1;
      end else begin
        bus_rs   = 1'b1;
        bus_data = char_q[pos];
      end
    end
    long_wait = !bus_rs && (bus_data == CMD_CLEAR);
  end

  always_comb begin
    dirty_d   = wr_en | (dirty_q & (state_q != StIdle));
    idle_next = ((state_q == StIdle) & ~dirty_q)
              | ((state_q == StInit) & bus_done & (idx_q == InitLastIdx))
              | ((state_q == StRefresh) & bus_done & (idx_q == RefLastIdx));
    busy_d    = ~(idle_next & ~dirty_d);
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      for (int i = 0; i < 32; i++) char_q[i] <= CHAR_SPACE;
    end else if (wr_en) begin
      char_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q   <= StPwrWait;
      pwr_cnt_q <= '0;
      idx_q     <= '0;
      dirty_q   <= 1'b1;
      busy_q    <= 1'b1;
    end else begin
      dirty_q <= dirty_d;
      busy_q  <= busy_d;
      unique case (state_q)
        StPwrWait: begin
          if (start) begin
            state_q <= StInit;
            idx_q   <= '0;
          end else begin
            pwr_cnt_q <= pwr_cnt_q + CntW'(1);
          end
        end
        StInit: begin
          if (bus_done) begin
            if (idx_q == InitLastIdx) state_q <= StIdle;
            else                      idx_q   <= issue_idx;
          end
        end
        StIdle: begin
          if (dirty_q) begin
            state_q <= StRefresh;
            idx_q   <= '0;
          end
        end
        StRefresh: begin
          if (bus_done) begin
            if (idx_q == RefLastIdx) state_q <= StIdle;
            else                     idx_q   <= issue_idx;
          end
        end
        default: state_q <= StPwrWait;
      endcase
    end
  end

  assign busy = busy_q;

  clcd_bus_cycle #(
    .E_HIGH_CYC  (E_HIGH_CYC),
    .CMD_WAIT_CYC(CMD_WAIT_CYC),
    .CLR_WAIT_CYC(CLR_WAIT_CYC),
    .CntW        (CntW)
  ) u_bus (
    .clk      (clk),
    .RESET    (RESET),
    .start    (start),
    .rs       (bus_rs),
    .data     (bus_data),
    .long_wait(long_wait),
    .done     (bus_done),
    .CLCD_RS  (CLCD_RS),
    .CLCD_RW  (CLCD_RW),
    .CLCD_E   (CLCD_E),
    .CLCD_DQ  (CLCD_DQ)
  );

`ifdef CLCD_RDBACK_EN
  logic [7:0] rd_data_q;

  // Reads the pre-write value when a write hits the same address this cycle.
  always_ff @(posedge clk) begin
    if (RESET) rd_data_q <= CHAR_SPACE;
    else       rd_data_q <= char_q[rd_addr];
  end

  assign rd_data = rd_data_q;
`else
  // Write-only buffer: no read port.
`endif

endmodule

// File: tb/tb_clcd_ctrl.sv
// Directed self-checking bench for clcd_ctrl with shortened timing parameters.
module tb_clcd_ctrl;

  localparam int unsigned PWR = 100;
  localparam int unsigned EH  = 4;
  localparam int unsigned CW  = 10;
  localparam int unsigned LW  = 40;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       busy, CLCD_RS, CLCD_RW, CLCD_E;
  logic [7:0] CLCD_DQ;
`ifdef CLCD_RDBACK_EN
  logic [4:0] rd_addr = 5'd8;
  logic [7:0] rd_data;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic       rs;
    logic [7:0] dq;
    int         cyc;
  } byte_t;
  byte_t log_q[$];

  always #5 clk = ~clk;

  clcd_ctrl #(
    .CLK_HZ      (50000000),
    .PWR_WAIT_CYC(PWR),
    .E_HIGH_CYC  (EH),
    .CMD_WAIT_CYC(CW),
    .CLR_WAIT_CYC(LW)
  ) dut (
    .clk    (clk),
    .RESET  (RESET),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
`ifdef CLCD_RDBACK_EN
    .rd_addr(rd_addr),
    .rd_data(rd_data),
`endif
    .busy   (busy),
    .CLCD_RS(CLCD_RS),
    .CLCD_RW(CLCD_RW),
    .CLCD_E (CLCD_E),
    .CLCD_DQ(CLCD_DQ)
  );

  // Cycle 1 is the first rising edge that samples RESET low.
  always @(posedge clk) begin
    if (RESET) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: logs each byte at E rise and checks E width and RS/DQ stability.
  logic       pe = 1'b0;
  logic [8:0] h1 = '0, h2 = '0, held = '0, cur;
  int         ehi = 0, hold = 0;
  bit         stab_bad = 1'b0;

  always @(posedge clk) begin
    #1;
    if (RESET) begin
      pe = 1'b0; h1 = '0; h2 = '0; ehi = 0; hold = 0; stab_bad = 1'b0;
    end else begin
      cur = {CLCD_RS, CLCD_DQ};
      if (CLCD_E && !pe) begin
        chk($sformatf("setup_stable_rw@%0d", cyc),
            {28'd0, hold == 0, cur == h1, cur == h2, CLCD_RW}, 32'hE);
        log_q.push_back('{rs: CLCD_RS, dq: CLCD_DQ, cyc: cyc});
        held = cur; stab_bad = 1'b0; ehi = 1;
      end else if (CLCD_E) begin
        if (cur != held) stab_bad = 1'b1;
        ehi++;
      end else if (pe) begin
        chk($sformatf("e_width@%0d", cyc), ehi, EH);
        hold = (held == 9'h001) ? LW : CW;
      end
      if (!CLCD_E && hold > 0) begin
        if (cur != held) stab_bad = 1'b1;
        hold--;
        if (hold == 0) chk($sformatf("rs_dq_hold@%0d", cyc), stab_bad, 0);
      end
      h2 = h1; h1 = cur; pe = CLCD_E;
    end
  end

  task automatic wait_bytes(input int n, input string tag);
    int budget = 4000;
    while (log_q.size() < n && budget > 0) begin
      @(posedge clk); #2;
      budget--;
    end
    chk(tag, log_q.size() >= n, 1);
  endtask

  task automatic wait_idle(output int c);
    int budget = 4000;
    bit seen = 1'b0;
    c = -1;
    while (!seen && budget > 0) begin
      @(posedge clk); #2;
      if (!busy) begin
        seen = 1'b1;
        c = cyc;
      end
      budget--;
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d, output int c);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1 c = cyc;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // One refresh pass starting at log entry base: 80, chars 0-15, C0, chars 16-31.
  task automatic check_pass(input int base, input logic [7:0] exp_buf [32], input string tag);
    logic [8:0] e;
    for (int i = 0; i < 34; i++) begin
      if (i == 0)       e = {1'b0, 8'h80};
      else if (i == 17) e = {1'b0, 8'hC0};
      else if (i < 17)  e = {1'b1, exp_buf[i-1]};
      else              e = {1'b1, exp_buf[i-2]};
      chk($sformatf("%s_byte%0d", tag, i), {log_q[base+i].rs, log_q[base+i].dq}, e);
    end
  endtask

  task automatic check_boot(input string tag);
    logic [7:0] init_exp [5];
    logic [7:0] blank [32];
    int c;
    init_exp = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    for (int i = 0; i < 32; i++) blank[i] = 8'h20;
    wait_bytes(39, {tag, "_bytes"});
    wait_idle(c);
    chk({tag, "_first_e_rise"}, log_q[0].cyc, 102);
    for (int i = 0; i < 5; i++)
      chk($sformatf("%s_init%0d", tag, i), {log_q[i].rs, log_q[i].dq}, {1'b0, init_exp[i]});
    chk({tag, "_cmd_spacing"}, log_q[1].cyc - log_q[0].cyc, 17);
    chk({tag, "_clear_wait"}, log_q[4].cyc - log_q[3].cyc, 47);
    check_pass(5, blank, {tag, "_blank"});
    chk({tag, "_busy_fall"}, c, 794);
    chk({tag, "_byte_count"}, log_q.size(), 39);
  endtask

  initial begin
    logic [7:0] exp_buf [32];
    int  w, c, budget;
    bit  early_idle, e_seen;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_e", CLCD_E, 0);
    chk("rst_rs", CLCD_RS, 0);
    chk("rst_rw", CLCD_RW, 0);
    chk("rst_dq", CLCD_DQ, 8'h00);
    chk("rst_busy", busy, 1);
`ifdef CLCD_RDBACK_EN
    chk("rst_rd_data", rd_data, 8'h20);
`endif
    @(negedge clk);
    RESET = 1'b0;
`ifdef CLCD_RDBACK_EN
    @(posedge clk); #1;
    chk("rd_addr8_after_reset", rd_data, 8'h20);
`endif

    // Power-on init and first blank repaint.
    check_boot("boot");

    // Writes at both ends of the buffer.
    for (int i = 0; i < 32; i++) exp_buf[i] = 8'h20;
    exp_buf[0] = 8'h41; exp_buf[31] = 8'h5A;
    log_q.delete();
    wr(5'd0, 8'h41, w);
    wr(5'd31, 8'h5A, c);
    wait_bytes(68, "az_bytes");
    wait_idle(c);
    chk("refresh_latency", log_q[0].cyc, w + 3);
    check_pass(0, exp_buf, "az_pass1");
    check_pass(34, exp_buf, "az_pass2");
    chk("az_byte_count", log_q.size(), 68);

    // Write landing mid-refresh forces a second full pass.
    log_q.delete();
    wr(5'd0, 8'h41, w);
    wait_bytes(7, "mid_pos5");
    wr(5'd20, 8'h42, w);
    exp_buf[20] = 8'h42;
    early_idle = 1'b0;
    budget = 4000;
    while (log_q.size() < 68 && budget > 0) begin
      @(posedge clk); #2;
      if (!busy) early_idle = 1'b1;
      budget--;
    end
    chk("mid_bytes", log_q.size() >= 68, 1);
    chk("mid_busy_held", early_idle, 0);
    wait_idle(c);
    check_pass(0, exp_buf, "mid_pass1");
    check_pass(34, exp_buf, "mid_pass2");
    chk("mid_byte_count", log_q.size(), 68);

    // One-cycle reset while E is high.
    log_q.delete();
    wr(5'd2, 8'h43, w);
    e_seen = 1'b0;
    budget = 200;
    while (!e_seen && budget > 0) begin
      @(posedge clk); #2;
      if (CLCD_E) e_seen = 1'b1;
      budget--;
    end
    chk("ehi_reached", e_seen, 1);
    @(negedge clk);
    RESET = 1'b1;
    @(posedge clk); #1;
    chk("midrst_e", CLCD_E, 0);
    chk("midrst_busy", busy, 1);
    chk("midrst_dq", CLCD_DQ, 8'h00);
    chk("midrst_rs", CLCD_RS, 0);
    @(negedge clk);
    RESET = 1'b0;
    log_q.delete();
    check_boot("reboot");

`ifdef CLCD_RDBACK_EN
    wr(5'd7, 8'h33, w);
    rd_addr = 5'd7;
    @(posedge clk); #1;
    chk("rd_addr7", rd_data, 8'h33);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 8'h44;
    @(posedge clk); #1;
    chk("rd_same_cycle_old", rd_data, 8'h33);
    @(negedge clk);
    wr_en = 1'b0;
    @(posedge clk); #1;
    chk("rd_after_write", rd_data, 8'h44);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
